vga_coord_fetcher: RTL

//  Per-frame sequencer that reads NUM_OBJ (x,y) coordinate pairs from the VGA

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_fetch_tag_pipe.sv | 34 +++
 rtl/vga_coord_fetcher.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding and coordinate helpers for the VGA coordinate fetcher
package vga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_COMMIT = 2'd3
   } fetch_state_t;

   localparam int DEFAULT_X_OFFSET = 32;

   // Low coord_w bits of a memory word, zero-extended.
   function automatic logic [31:0] coord_slice(input logic [31:0] word, input int coord_w);
      logic [31:0] mask;
      mask = (coord_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << coord_w) - 32'd1);
      return word & mask;
   endfunction

endpackage

// File: rtl/vga_fetch_tag_pipe.sv
// rtl/vga_fetch_tag_pipe.sv - {valid, index} delay line matching the memory read latency
module vga_fetch_tag_pipe #(
   parameter int DEPTH = 1,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   logic [DEPTH-1:0] valid_q;
   logic [IDX_W-1:0] idx_q [DEPTH];

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int k = 0; k < DEPTH; k++) idx_q[k] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         idx_q[0]   <= in_idx;
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            idx_q[k]   <= idx_q[k-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/vga_coord_fetcher.sv
// rtl/vga_coord_fetcher.sv - per-frame fetch of object coordinates with shadow buffering
module vga_coord_fetcher
   import vga_pkg::*;
#(
   parameter int NUM_OBJ   = 3,
   parameter int COORD_W   = 10,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0,
   parameter int X_OFFSET  = DEFAULT_X_OFFSET,
   parameter bit CLAMP_X   = 1'b1,
   parameter int MEM_LAT   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_start,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr,
   input  logic [DATA_W-1:0]          data_from_mem_vga,
   output logic [NUM_OBJ*COORD_W-1:0] obj_x,
   output logic [NUM_OBJ*COORD_W-1:0] obj_y,
   output logic                       busy,
   output logic                       coords_updated,
   output logic                       overrun
);

   localparam int                 NUM_WORDS = 2 * NUM_OBJ;
   localparam int                 IDX_W     = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [COORD_W:0]   X_OFF     = (COORD_W+1)'(X_OFFSET);

   fetch_state_t               state;
   logic [IDX_W-1:0]           idx;
   logic [IDX_W-1:0]           issue_idx;
   logic                       pipe_valid;
   logic [IDX_W-1:0]           pipe_idx;
   logic [NUM_OBJ*COORD_W-1:0] shadow_x;
   logic [NUM_OBJ*COORD_W-1:0] shadow_y;
   logic [COORD_W-1:0]         word_coord;
   logic [COORD_W:0]           x_diff;
   logic [COORD_W-1:0]         x_adj;
   int                         cap_obj;

   vga_fetch_tag_pipe #(
      .DEPTH (MEM_LAT),
      .IDX_W (IDX_W)
   ) u_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mem_rd_en),
      .in_idx    (issue_idx),
      .out_valid (pipe_valid),
      .out_idx   (pipe_idx)
   );

   // Borrow out of the extra MSB means the raw X was below the offset.
   always_comb begin
      word_coord = COORD_W'(coord_slice(32'(data_from_mem_vga), COORD_W));
      x_diff     = {1'b0, word_coord} - X_OFF;
      x_adj      = (CLAMP_X && x_diff[COORD_W]) ? '0 : x_diff[COORD_W-1:0];
      cap_obj    = int'(pipe_idx >> 1);
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         shadow_x <= '0;
         shadow_y <= '0;
      end else if (pipe_valid) begin
         if (!pipe_idx[0]) shadow_x[cap_obj*COORD_W +: COORD_W] <= x_adj;
         else              shadow_y[cap_obj*COORD_W +: COORD_W] <= word_coord;
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         idx            <= '0;
         issue_idx      <= '0;
         mem_rd_en      <= 1'b0;
         mem_addr       <= '0;
         busy           <= 1'b0;
         coords_updated <= 1'b0;
         overrun        <= 1'b0;
         obj_x          <= '0;
         obj_y          <= '0;
      end else begin
         mem_rd_en      <= 1'b0;
         coords_updated <= 1'b0;
         if (frame_start && state != ST_IDLE) overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state <= ST_ISSUE;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_ISSUE: begin
               mem_rd_en <= 1'b1;
               mem_addr  <= BASE + ADDR_W'(idx);
               issue_idx <= idx;
               idx       <= idx + 1'b1;
               if (idx == LAST_IDX) state <= ST_DRAIN;
            end
            // Words return in issue order, so the last tag means the shadow is complete.
            ST_DRAIN: begin
               if (pipe_valid && pipe_idx == LAST_IDX) state <= ST_COMMIT;
            end
            ST_COMMIT: begin
               obj_x          <= shadow_x;
               obj_y          <= shadow_y;
               busy           <= 1'b0;
               coords_updated <= 1'b1;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
